regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised register file for the datapath with two combinational read ports, one write-back port that can also write a high word to a fixed high-word register, and a per-register pending-write scoreboard. Same-cycle write-back-to-read bypass and hazard flags let decode detect RAW hazards directly. It sits between decode (issue and read side) and write-back (write side).

## Interface

- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- HI_REG, 0, index of the register that receives the high word of a wide write
- MAX_PEND, 3, maximum outstanding writes tracked per register (1..7)

- clockg  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- halt_sys  in  1  freezes every state update while high
- ra1, ra2  in  ADDR_W  read addresses
- r0_read  in  1  port 2 reads HI_REG instead of ra2
- rd1, rd2  out  DATA_W  read data
- rd1_busy, rd2_busy  out  1  read data not yet valid (RAW hazard)
- issue_valid  in  1  decode issues an instruction that will write a register
- issue_dst  in  ADDR_W  destination of the issued instruction
- issue_wide  in  1  issued instruction also writes HI_REG
- issue_stall  out  1  issue refused, because a scoreboard counter is saturated
- wb_en  in  1  write-back valid
- wb_wide  in  1  write-back also writes the high word to HI_REG
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  2*DATA_W  {high word, low word}
- pending_any  out  1  at least one scoreboard counter is nonzero
- err_underflow  out  1  sticky: a write-back arrived at a register whose counter was 0

## Operation

- Storage: 2**ADDR_W x DATA_W registers. Each register has a pending counter of ceil(log2(MAX_PEND+1)) bits.
- Write: this happens when wb_en is high and halt_sys is low (a "wb fire").
  - reg[wb_addr] <= wb_data[DATA_W-1:0].
  - If wb_wide is high, reg[HI_REG] <= wb_data[2*DATA_W-1:DATA_W].
  - If wb_wide is high and wb_addr == HI_REG, the low word wins.
- Read:
  - rd1 = reg[ra1].
  - rd2 = reg[HI_REG] when r0_read is high, else reg[ra2].
  - Bypass: on a wb fire, a read address matching a written register returns the incoming word, using the same precedence as the write.
- Issue: an issue fires when issue_valid is high, halt_sys is low and issue_stall is low.
  - issue_stall = issue_valid & (cnt[issue_dst]==MAX_PEND | (issue_wide & cnt[HI_REG]==MAX_PEND)).
  - issue_stall is asserted even while halt_sys is high.
- Counter update, per register, at most one step per cycle:
  - An issue fire targeting the register increments the counter.
  - A wb fire targeting the register decrements the counter.
  - If both happen in the same cycle, the counter is unchanged.
  - A wide issue or wide write-back with address == HI_REG counts once.
- Underflow: a wb fire to a register whose counter is 0 still writes the data. The counter stays 0 and err_underflow sets. err_underflow clears only on rst.
- Hazard flags, for each read port p:
  - rdp_busy = cnt[addr_p] > 1, or cnt[addr_p] == 1 with no wb fire to addr_p this cycle.
  - addr_p is HI_REG for port 2 when r0_read is high.
  - A counter of 1 with a matching wb fire is not busy, because the bypass supplies the data.
- pending_any = OR of all counters being nonzero, taken from registered state.
- halt_sys: no register or counter changes and bypass is disabled. Reads continue from stored state, and busy flags are computed with no wb fire.

## Timing

- Reset (asynchronous, immediate):
  - All registers are 0 and all counters are 0.
  - err_underflow = 0 and pending_any = 0.
  - rd1 = rd2 = 0, rd1_busy = rd2_busy = 0, issue_stall = 0.
  - Reset asserted mid-operation discards all pending state. Write-backs after reset are treated as underflow.
- Reads, bypass, busy flags and issue_stall are combinational, with zero-cycle latency.
- A write is visible from stored state on the cycle after the edge, and in the same cycle through the bypass.
- Counter changes take effect at the edge. A register issued in cycle N reads busy from cycle N+1.
- No handshake on write-back: every wb fire is accepted. Issue handshake: the issue is accepted iff issue_valid & !issue_stall & !halt_sys at the edge.

## Test plan

- Reset then write: rst pulse, then wb_en with wb_addr=3, wb_data=32'h0000_BEEF, and ra1=3. rd1=16'hBEEF in the same cycle (bypass) and on the following cycles from stored state.
- Wide write: wb_wide=1, wb_addr=5, wb_data=32'h1234_5678. Next cycle rd1(ra1=5)=16'h5678, and rd2 with r0_read=1 gives 16'h1234. Repeat with wb_addr=HI_REG: HI_REG=16'h5678.
- Scoreboard:
  - Issue dst=7 twice: cnt[7]=2 and rd1_busy=1 for ra1=7.
  - First wb to 7: rd1_busy stays 1.
  - Second wb to 7: rd1_busy=0 in that cycle, and pending_any=0 afterwards.
- Saturation: with MAX_PEND=3, three issues to dst=2, then a fourth. issue_stall=1 and the counter stays 3. A simultaneous issue and wb to 2 with counter 2 leaves it at 2.
- Halt and underflow:
  - halt_sys=1 with wb_en to addr 4: no write and no counter change, and rd1 shows the old value.
  - With halt_sys=0, a wb to addr 9 with cnt 0 writes the data and sets err_underflow=1, which holds until rst.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two bypassed read ports, a wide-capable write-back
// port and a per-register pending-write scoreboard for RAW hazard detection.

// Per-register pending-write counter; one step per cycle at most.
module regfile_sb_cnt #(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2
) (
  input  logic             clockg,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             uflow
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc/dec cancel, dec at zero sticks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      if (cnt_q != CNT_W'(MAX_PEND)) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clockg or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt   = cnt_q;
  assign uflow = dec & (cnt_q == '0);
endmodule

module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int HI_REG   = 0,
  parameter int MAX_PEND = 3
) (
  input  logic                clockg,
  input  logic                rst,
  input  logic                halt_sys,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  input  logic                r0_read,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  output logic                rd1_busy,
  output logic                rd2_busy,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dst,
  input  logic                issue_wide,
  output logic                issue_stall,
  input  logic                wb_en,
  input  logic                wb_wide,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [2*DATA_W-1:0] wb_data,
  output logic                pending_any,
  output logic                err_underflow
);
  localparam int              DEPTH = 1 << ADDR_W;
  localparam int              CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [ADDR_W-1:0] HI_A = ADDR_W'(HI_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0][CNT_W-1:0] cnt;
  logic [DEPTH-1:0] inc, dec, uflow;
  logic err_underflow_q, err_underflow_d;

  logic              wb_fire, iss_fire;
  logic [DATA_W-1:0] wb_lo, wb_hi;
  logic [ADDR_W-1:0] ra2_eff;

  assign wb_fire = wb_en & ~halt_sys;
  assign wb_lo   = wb_data[DATA_W-1:0];
  assign wb_hi   = wb_data[2*DATA_W-1:DATA_W];
  assign ra2_eff = r0_read ? HI_A : ra2;

  assign issue_stall = issue_valid &
                       ((cnt[issue_dst] == CNT_W'(MAX_PEND)) |
                        (issue_wide & (cnt[HI_A] == CNT_W'(MAX_PEND))));
  assign iss_fire    = issue_valid & ~halt_sys & ~issue_stall;

  // Per-register hit decode and counter instances; a wide op aimed at
  // HI_REG itself is a single hit.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    assign dec[i] = wb_fire &
                    ((wb_addr == ADDR_W'(i)) | (wb_wide & (i == HI_REG)));
    assign inc[i] = iss_fire &
                    ((issue_dst == ADDR_W'(i)) | (issue_wide & (i == HI_REG)));
    regfile_sb_cnt #(.MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) u_cnt (
      .clockg (clockg),
      .rst    (rst),
      .inc    (inc[i]),
      .dec    (dec[i]),
      .cnt    (cnt[i]),
      .uflow  (uflow[i])
    );
  end

  // Storage next-state: low word overrides the high word on HI_REG.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_fire && wb_wide && (i == HI_REG)) regs_d[i] = wb_hi;
      if (wb_fire && (wb_addr == ADDR_W'(i)))  regs_d[i] = wb_lo;
    end
    err_underflow_d = err_underflow_q | (|uflow);
  end

  // Register array and sticky underflow flag.
  always_ff @(posedge clockg or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      err_underflow_q <= err_underflow_d;
    end
  end

  // Read ports with same-cycle write-back bypass and hazard flags.
  always_comb begin
    rd1 = regs_q[ra1];
    if (wb_fire && wb_wide && (ra1 == HI_A)) rd1 = wb_hi;
    if (wb_fire && (ra1 == wb_addr))         rd1 = wb_lo;
    rd2 = regs_q[ra2_eff];
    if (wb_fire && wb_wide && (ra2_eff == HI_A)) rd2 = wb_hi;
    if (wb_fire && (ra2_eff == wb_addr))         rd2 = wb_lo;
    // A count of 1 being retired this cycle is covered by the bypass.
    rd1_busy = (cnt[ra1] > CNT_W'(1)) |
               ((cnt[ra1] == CNT_W'(1)) & ~dec[ra1]);
    rd2_busy = (cnt[ra2_eff] > CNT_W'(1)) |
               ((cnt[ra2_eff] == CNT_W'(1)) & ~dec[ra2_eff]);
  end

  assign pending_any   = |cnt;
  assign err_underflow = err_underflow_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;
  logic        clockg = 1'b0;
  logic        rst, halt_sys, r0_read;
  logic [3:0]  ra1, ra2, issue_dst, wb_addr;
  logic [15:0] rd1, rd2;
  logic        rd1_busy, rd2_busy, issue_valid, issue_wide, issue_stall;
  logic        wb_en, wb_wide, pending_any, err_underflow;
  logic [31:0] wb_data;
  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .HI_REG(0), .MAX_PEND(3)) dut (
    .clockg(clockg), .rst(rst), .halt_sys(halt_sys),
    .ra1(ra1), .ra2(ra2), .r0_read(r0_read), .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_wide(issue_wide),
    .issue_stall(issue_stall), .wb_en(wb_en), .wb_wide(wb_wide),
    .wb_addr(wb_addr), .wb_data(wb_data), .pending_any(pending_any),
    .err_underflow(err_underflow)
  );

  always #5 clockg = ~clockg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed at edge+1.
  task automatic tick();
    @(posedge clockg);
    #1;
  endtask

  task automatic idle();
    halt_sys = 0; issue_valid = 0; issue_dst = 0; issue_wide = 0;
    wb_en = 0; wb_wide = 0; wb_addr = 0; wb_data = 0;
  endtask

  initial begin
    rst = 1; r0_read = 0; ra1 = 0; ra2 = 0;
    idle();
    #3;
    chk("rst_rd1", rd1, 0);
    chk("rst_rd2", rd2, 0);
    chk("rst_busy", {rd1_busy, rd2_busy}, 0);
    chk("rst_stall", issue_stall, 0);
    chk("rst_pend", pending_any, 0);
    chk("rst_err", err_underflow, 0);
    tick();
    rst = 0;

    // Write with bypass, then stored read; counter 0 so underflow sets.
    wb_en = 1; wb_addr = 3; wb_data = 32'h0000_BEEF; ra1 = 3;
    #1 chk("byp_rd1", rd1, 16'hBEEF);
    tick(); idle();
    #1 chk("stored_rd1", rd1, 16'hBEEF);
    chk("uflow_first_wb", err_underflow, 1);
    tick();
    chk("stored_rd1_2", rd1, 16'hBEEF);

    // Wide write to 5, high word lands in register 0.
    wb_en = 1; wb_wide = 1; wb_addr = 5; wb_data = 32'h1234_5678;
    tick(); idle();
    ra1 = 5; r0_read = 1;
    #1 chk("wide_lo", rd1, 16'h5678);
    chk("wide_hi", rd2, 16'h1234);
    // Wide write aimed at HI_REG: low word wins, also through the bypass.
    wb_en = 1; wb_wide = 1; wb_addr = 0; wb_data = 32'hAAAA_9999;
    #1 chk("wide_hi_byp", rd2, 16'h9999);
    tick(); idle();
    #1 chk("wide_hi_stored", rd2, 16'h9999);
    r0_read = 0; ra2 = 3;
    #1 chk("rd2_ra2", rd2, 16'hBEEF);

    // Scoreboard: two issues to 7, then two write-backs.
    ra1 = 7; issue_valid = 1; issue_dst = 7;
    #1 chk("no_busy_before_issue", rd1_busy, 0);
    tick();
    chk("busy_after_issue1", rd1_busy, 1);
    tick(); idle();
    #1 chk("busy_cnt2", rd1_busy, 1);
    chk("pend_cnt2", pending_any, 1);
    wb_en = 1; wb_addr = 7; wb_data = 32'h0000_0007;
    #1 chk("busy_wb1", rd1_busy, 1);
    tick();
    wb_data = 32'h0000_0077;
    #1 chk("busy_wb2", rd1_busy, 0);
    chk("byp_wb2", rd1, 16'h0077);
    tick(); idle();
    #1 chk("pend_cleared", pending_any, 0);
    chk("rd1_wb2_stored", rd1, 16'h0077);

    // Saturation at MAX_PEND=3 on register 2.
    ra1 = 2; issue_valid = 1; issue_dst = 2;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_below_max", issue_stall, 0);
      tick();
    end
    #1 chk("stall_at_max", issue_stall, 1);
    tick(); idle();
    wb_en = 1; wb_addr = 2;                       // cnt 3 -> 2
    #1 chk("busy_cnt3_wb", rd1_busy, 1);
    tick();
    issue_valid = 1; issue_dst = 2;               // cnt 2 -> 2
    #1 chk("stall_cnt2", issue_stall, 0);
    chk("busy_cnt2_both", rd1_busy, 1);
    tick(); idle();
    wb_en = 1; wb_addr = 2;                       // still 2: busy despite wb
    #1 chk("busy_cnt2_after_both", rd1_busy, 1);
    tick(); idle();                               // cnt 1
    #1 chk("busy_cnt1_idle", rd1_busy, 1);
    wb_en = 1; wb_addr = 2;
    #1 chk("busy_cnt1_wb", rd1_busy, 0);
    tick(); idle();
    #1 chk("pend_after_sat", pending_any, 0);

    // Mid-operation reset discards pending state.
    issue_valid = 1; issue_dst = 4;
    tick(); idle();
    #1 chk("pend_before_rst", pending_any, 1);
    rst = 1;
    #1 chk("pend_rst_async", pending_any, 0);
    chk("err_rst_async", err_underflow, 0);
    chk("rd1_rst_async", rd1, 0);
    tick();
    rst = 0;

    // Halt: no write, no bypass, no counter change.
    ra1 = 4; halt_sys = 1; wb_en = 1; wb_addr = 4; wb_data = 32'h0000_4444;
    issue_valid = 1; issue_dst = 4;
    #1 chk("halt_no_byp", rd1, 0);
    tick(); idle();
    #1 chk("halt_no_write", rd1, 0);
    chk("halt_no_cnt", pending_any, 0);
    chk("halt_no_err", err_underflow, 0);

    // Underflow on register 9.
    ra1 = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h0000_0909;
    #1 chk("uflow_byp", rd1, 16'h0909);
    tick(); idle();
    #1 chk("uflow_stored", rd1, 16'h0909);
    chk("uflow_set", err_underflow, 1);
    chk("uflow_cnt_zero", pending_any, 0);
    tick(); tick();
    chk("uflow_sticky", err_underflow, 1);
    rst = 1;
    #1 chk("uflow_cleared", err_underflow, 0);
    tick();
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
